// File: rtl/trd_fetch_sched.sv
// Per-thread PC bank and round-robin fetch scheduler for the 8-thread barrel pipeline.
// One-cycle registered selection; stall holds the selection while PC writes and miss tracking continue.
module trd_fetch_sched #(
  parameter int          NUM_TRD = 8,
  parameter logic [31:0] RST_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] nxt_pc_0,
  input  logic [31:0] nxt_pc_1,
  input  logic [31:0] nxt_pc_2,
  input  logic [31:0] nxt_pc_3,
  input  logic [31:0] nxt_pc_4,
  input  logic [31:0] nxt_pc_5,
  input  logic [31:0] nxt_pc_6,
  input  logic [31:0] nxt_pc_7,
  input  logic [7:0]  pc_wr,
  input  logic [7:0]  trd_en,
  input  logic        i_miss,
  input  logic [2:0]  i_miss_trd,
  input  logic        d_miss,
  input  logic [2:0]  d_miss_trd,
  input  logic        refill_done,
  input  logic [2:0]  refill_trd,
  input  logic        stall,
  output logic [2:0]  cur_trd,
  output logic [31:0] cur_pc,
  output logic        i_rd,
  output logic [7:0]  trd_wait
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_nxt;
  logic [31:0] nxt_pc [NUM_TRD];
  logic [31:0] pc_q   [NUM_TRD];
  logic [7:0]  miss_now, clr_now, wait_nxt, elig;
  logic        found;
  logic [2:0]  win;
  logic [31:0] win_pc;
  logic [2:0]  trd_nxt;
  logic [31:0] pc_nxt;
  logic        ird_nxt;

  assign nxt_pc[0] = nxt_pc_0;
  assign nxt_pc[1] = nxt_pc_1;
  assign nxt_pc[2] = nxt_pc_2;
  assign nxt_pc[3] = nxt_pc_3;
  assign nxt_pc[4] = nxt_pc_4;
  assign nxt_pc[5] = nxt_pc_5;
  assign nxt_pc[6] = nxt_pc_6;
  assign nxt_pc[7] = nxt_pc_7;

  // PC bank: writes land regardless of stall or thread enable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_TRD; k++) pc_q[k] <= RST_PC;
    end else begin
      for (int k = 0; k < NUM_TRD; k++) begin
        if (pc_wr[k]) pc_q[k] <= nxt_pc[k];
      end
    end
  end

  always_comb begin
    miss_now = '0;
    clr_now  = '0;
    if (i_miss)      miss_now[i_miss_trd] = 1'b1;
    if (d_miss)      miss_now[d_miss_trd] = 1'b1;
    if (refill_done) clr_now[refill_trd]  = 1'b1;
  end

  // Set after clear so a same-cycle miss keeps the thread parked
  assign wait_nxt = (trd_wait & ~clr_now) | miss_now;
  assign elig     = trd_en & ~trd_wait & ~miss_now;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) trd_wait <= '0;
    else        trd_wait <= wait_nxt;
  end

  // Round-robin search starting one past the current thread, ending on it
  always_comb begin
    logic [2:0] idx;
    idx   = '0;
    found = 1'b0;
    win   = cur_trd;
    for (int i = 1; i <= NUM_TRD; i++) begin
      idx = cur_trd + 3'(i);
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  // Bypass a same-cycle PC write so a redirect is fetched immediately
  assign win_pc = pc_wr[win] ? nxt_pc[win] : pc_q[win];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  always_comb begin
    state_nxt = state_q;
    trd_nxt   = cur_trd;
    pc_nxt    = cur_pc;
    ird_nxt   = i_rd;
    if (!stall) begin
      if (found) begin
        state_nxt = RUN;
        trd_nxt   = win;
        pc_nxt    = win_pc;
        ird_nxt   = 1'b1;
      end else begin
        state_nxt = IDLE;
        ird_nxt   = 1'b0;
      end
    end else if (miss_now[cur_trd] || !trd_en[cur_trd]) begin
      ird_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_trd <= 3'd7;
      cur_pc  <= RST_PC;
      i_rd    <= 1'b0;
    end else begin
      cur_trd <= trd_nxt;
      cur_pc  <= pc_nxt;
      i_rd    <= ird_nxt;
    end
  end

endmodule

// File: tb/tb_trd_fetch_sched.sv
// Directed bench for trd_fetch_sched: each driven cycle queues its hand-computed
// expected outputs; a monitor pops and compares one entry after every rising edge.
module tb_trd_fetch_sched;

  localparam logic [31:0] RPC = 32'h0000_1000;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] nxt_pc_0, nxt_pc_1, nxt_pc_2, nxt_pc_3;
  logic [31:0] nxt_pc_4, nxt_pc_5, nxt_pc_6, nxt_pc_7;
  logic [7:0]  pc_wr, trd_en;
  logic        i_miss, d_miss, refill_done, stall;
  logic [2:0]  i_miss_trd, d_miss_trd, refill_trd;
  logic [2:0]  cur_trd;
  logic [31:0] cur_pc;
  logic        i_rd;
  logic [7:0]  trd_wait;

  typedef struct {
    logic [2:0]  trd;
    logic [31:0] pc;
    logic        ird;
    logic [7:0]  wt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  trd_fetch_sched #(.NUM_TRD(8), .RST_PC(RPC)) dut (
    .clk(clk), .rst_n(rst_n),
    .nxt_pc_0(nxt_pc_0), .nxt_pc_1(nxt_pc_1), .nxt_pc_2(nxt_pc_2), .nxt_pc_3(nxt_pc_3),
    .nxt_pc_4(nxt_pc_4), .nxt_pc_5(nxt_pc_5), .nxt_pc_6(nxt_pc_6), .nxt_pc_7(nxt_pc_7),
    .pc_wr(pc_wr), .trd_en(trd_en),
    .i_miss(i_miss), .i_miss_trd(i_miss_trd), .d_miss(d_miss), .d_miss_trd(d_miss_trd),
    .refill_done(refill_done), .refill_trd(refill_trd), .stall(stall),
    .cur_trd(cur_trd), .cur_pc(cur_pc), .i_rd(i_rd), .trd_wait(trd_wait)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic clr_pulses();
    pc_wr       = '0;
    i_miss      = 1'b0;
    d_miss      = 1'b0;
    refill_done = 1'b0;
  endtask

  // Queue the outputs expected after the coming edge, then move to the next falling edge
  task automatic tick(input logic [2:0] t, input logic [31:0] p, input logic r, input logic [7:0] w);
    exp_t e;
    e.trd = t; e.pc = p; e.ird = r; e.wt = w;
    exp_q.push_back(e);
    @(negedge clk);
    clr_pulses();
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("cur_trd",  {29'd0, cur_trd}, {29'd0, e.trd});
        chk("cur_pc",   cur_pc,           e.pc);
        chk("i_rd",     {31'd0, i_rd},    {31'd0, e.ird});
        chk("trd_wait", {24'd0, trd_wait}, {24'd0, e.wt});
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    rst_n = 1'b0;
    stall = 1'b0;
    trd_en = '0;
    i_miss_trd = '0; d_miss_trd = '0; refill_trd = '0;
    nxt_pc_0 = '0; nxt_pc_1 = '0; nxt_pc_2 = '0; nxt_pc_3 = '0;
    nxt_pc_4 = '0; nxt_pc_5 = '0; nxt_pc_6 = '0; nxt_pc_7 = '0;
    clr_pulses();
    repeat (2) @(negedge clk);
    chk("rst_cur_trd",  {29'd0, cur_trd}, 32'd7);
    chk("rst_cur_pc",   cur_pc, RPC);
    chk("rst_i_rd",     {31'd0, i_rd}, 32'd0);
    chk("rst_trd_wait", {24'd0, trd_wait}, 32'd0);
    rst_n  = 1'b1;
    trd_en = 8'hFF;

    // Full round robin; threads 6 and 7 written together while 1 is fetched
    tick(3'd0, RPC, 1'b1, 8'h00);
    pc_wr = 8'hC0; nxt_pc_6 = 32'h0000_2060; nxt_pc_7 = 32'h0000_2070;
    tick(3'd1, RPC, 1'b1, 8'h00);
    for (int k = 2; k <= 5; k++) tick(3'(k), RPC, 1'b1, 8'h00);
    tick(3'd6, 32'h0000_2060, 1'b1, 8'h00);
    tick(3'd7, 32'h0000_2070, 1'b1, 8'h00);
    tick(3'd0, RPC, 1'b1, 8'h00);

    // Sparse enable masks
    trd_en = 8'b0010_0100;
    tick(3'd2, RPC, 1'b1, 8'h00);
    tick(3'd5, RPC, 1'b1, 8'h00);
    tick(3'd2, RPC, 1'b1, 8'h00);
    tick(3'd5, RPC, 1'b1, 8'h00);
    trd_en = 8'b0000_1000;
    tick(3'd3, RPC, 1'b1, 8'h00);
    tick(3'd3, RPC, 1'b1, 8'h00);

    // I-miss on thread 4 skips it; refill two cycles later releases it
    trd_en = 8'hFF;
    i_miss = 1'b1; i_miss_trd = 3'd4;
    tick(3'd5, RPC, 1'b1, 8'h10);
    tick(3'd6, 32'h0000_2060, 1'b1, 8'h10);
    refill_done = 1'b1; refill_trd = 3'd4;
    tick(3'd7, 32'h0000_2070, 1'b1, 8'h00);
    tick(3'd0, RPC, 1'b1, 8'h00);
    tick(3'd1, RPC, 1'b1, 8'h00);
    // Redirect of thread 2 in the cycle it wins is fetched with the new PC
    pc_wr = 8'h04; nxt_pc_2 = 32'h0000_0100;
    tick(3'd2, 32'h0000_0100, 1'b1, 8'h00);
    tick(3'd3, RPC, 1'b1, 8'h00);
    tick(3'd4, RPC, 1'b1, 8'h00);
    tick(3'd5, RPC, 1'b1, 8'h00);
    tick(3'd6, 32'h0000_2060, 1'b1, 8'h00);

    // Stall on thread 6; PC write still lands, D-miss drops i_rd
    stall = 1'b1;
    pc_wr = 8'h40; nxt_pc_6 = 32'h0000_3000;
    tick(3'd6, 32'h0000_2060, 1'b1, 8'h00);
    d_miss = 1'b1; d_miss_trd = 3'd6;
    tick(3'd6, 32'h0000_2060, 1'b0, 8'h40);
    tick(3'd6, 32'h0000_2060, 1'b0, 8'h40);
    stall = 1'b0;
    tick(3'd7, 32'h0000_2070, 1'b1, 8'h40);
    tick(3'd0, RPC, 1'b1, 8'h40);
    tick(3'd1, RPC, 1'b1, 8'h40);
    tick(3'd2, 32'h0000_0100, 1'b1, 8'h40);
    tick(3'd3, RPC, 1'b1, 8'h40);
    tick(3'd4, RPC, 1'b1, 8'h40);
    tick(3'd5, RPC, 1'b1, 8'h40);
    tick(3'd7, 32'h0000_2070, 1'b1, 8'h40);
    refill_done = 1'b1; refill_trd = 3'd6;
    tick(3'd0, RPC, 1'b1, 8'h00);
    tick(3'd1, RPC, 1'b1, 8'h00);
    tick(3'd2, 32'h0000_0100, 1'b1, 8'h00);
    for (int k = 3; k <= 5; k++) tick(3'(k), RPC, 1'b1, 8'h00);
    tick(3'd6, 32'h0000_3000, 1'b1, 8'h00);

    // Park every thread, two misses per cycle
    i_miss = 1'b1; i_miss_trd = 3'd0; d_miss = 1'b1; d_miss_trd = 3'd1;
    tick(3'd7, 32'h0000_2070, 1'b1, 8'h03);
    i_miss = 1'b1; i_miss_trd = 3'd2; d_miss = 1'b1; d_miss_trd = 3'd3;
    tick(3'd4, RPC, 1'b1, 8'h0F);
    i_miss = 1'b1; i_miss_trd = 3'd4; d_miss = 1'b1; d_miss_trd = 3'd5;
    tick(3'd6, 32'h0000_3000, 1'b1, 8'h3F);
    i_miss = 1'b1; i_miss_trd = 3'd6; d_miss = 1'b1; d_miss_trd = 3'd7;
    tick(3'd6, 32'h0000_3000, 1'b0, 8'hFF);
    refill_done = 1'b1; refill_trd = 3'd1; i_miss = 1'b1; i_miss_trd = 3'd1;
    tick(3'd6, 32'h0000_3000, 1'b0, 8'hFF);
    tick(3'd6, 32'h0000_3000, 1'b0, 8'hFF);
    refill_done = 1'b1; refill_trd = 3'd3;
    tick(3'd6, 32'h0000_3000, 1'b0, 8'hF7);
    tick(3'd3, RPC, 1'b1, 8'hF7);

    // Asynchronous reset mid-run
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cur_trd",  {29'd0, cur_trd}, 32'd7);
    chk("arst_cur_pc",   cur_pc, RPC);
    chk("arst_i_rd",     {31'd0, i_rd}, 32'd0);
    chk("arst_trd_wait", {24'd0, trd_wait}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k <= 6; k++) tick(3'(k), RPC, 1'b1, 8'h00);

    @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/trd_fetch_sched.md
Name: trd_fetch_sched

Overview:
- Per-thread PC bank and round-robin fetch thread scheduler for the 8-thread barrel pipeline.
- Holds the architectural fetch PC of every hardware thread and absorbs the per-thread next-PC/write-enable vectors produced by the PC selector.
- Each unstalled cycle, picks the next eligible thread and presents cur_trd/cur_pc/i_rd to the I-cache fetch stage; the same values feed back to the PC selector.
- Tracks threads parked on outstanding I/D misses and skips them until their refill completes.

Parameters:
NUM_TRD, 8, number of hardware threads; thread id width is 3; only 8 is supported.
RST_PC, START_PC, PC loaded into every thread register on reset.

Ports:
clk  in  1  core clock
rst_n  in  1  reset
nxt_pc_0 .. nxt_pc_7  in  32 each  candidate next PC per thread, from the PC selector
pc_wr  in  8  per-thread PC write enable, from the PC selector
trd_en  in  8  thread enable mask; only enabled threads are eligible
i_miss  in  1  I-cache miss
i_miss_trd  in  3  thread of the I-cache miss
d_miss  in  1  D-cache miss
d_miss_trd  in  3  thread of the D-cache miss
refill_done  in  1  miss for refill_trd has been serviced
refill_trd  in  3  thread being released
stall  in  1  pipeline stall; hold the fetch selection
cur_trd  out  3  thread selected for fetch (registered)
cur_pc  out  32  PC of cur_trd (registered)
i_rd  out  1  fetch valid (registered)
trd_wait  out  8  per-thread miss-wait mask (registered)

Behaviour:
- Interface: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values:
  - All eight PC registers = RST_PC.
  - trd_wait = 0.
  - cur_trd = 7, so the first search starts at thread 0.
  - cur_pc = RST_PC.
  - i_rd = 0.
  - Scheduler state = IDLE.
- Reset asserted mid-operation discards all state immediately.
- PC bank:
  - pc_wr[k] = 1 → pc_k <= nxt_pc_k at the next edge.
  - Multiple threads may be written in the same cycle.
  - Writes are independent of stall.
- Wait mask:
  - Set: i_miss sets wait[i_miss_trd]; d_miss sets wait[d_miss_trd].
  - Clear: refill_done clears wait[refill_trd].
  - Set and clear on the same thread in the same cycle → set wins.
  - The mask is updated every cycle regardless of stall.
- Eligibility: elig[k] = trd_en[k] & ~wait[k] & ~(same-cycle miss for k).
- Selection (only when stall = 0):
  - Search threads cur_trd+1, cur_trd+2, ... cur_trd in order, modulo 8 (7 wraps to 0).
  - The first thread with elig = 1 wins, so a sole eligible thread is reselected every cycle.
  - Winner w: cur_trd <= w; i_rd <= 1; cur_pc <= (pc_wr[w] ? nxt_pc_w : pc_w). This bypass makes a redirect written this cycle be fetched immediately.
  - No eligible thread: cur_trd and cur_pc hold; i_rd <= 0.
- Stall = 1:
  - cur_trd and cur_pc hold.
  - i_rd holds, except it is forced to 0 when the held cur_trd takes a miss in that cycle or trd_en[cur_trd] = 0.
- Scheduler FSM:
  - IDLE → RUN when any elig = 1 and stall = 0.
  - RUN → IDLE when no elig = 1 and stall = 0.
  - i_rd = 1 only in RUN; the state is otherwise informational.
- Latency:
  - Miss to skip: the missing thread is never selected in the cycle of the miss or after it.
  - Refill to selectable: a thread released by refill_done is selectable from the following cycle.
- pc_wr / nxt_pc values for disabled threads are still written into the PC bank.

Test Plan:
1. Reset, trd_en = 8'hFF, no misses, stall = 0 → cur_trd sequence 0,1,...,7,0 with i_rd = 1 from the first edge after reset; each cur_pc = RST_PC until that thread is written.
2. trd_en = 8'b0010_0100 → cur_trd alternates 2,5,2,5; trd_en = 8'b0000_1000 → cur_trd = 3 every cycle.
3. i_miss with i_miss_trd = 4 while cur_trd = 3 → selection goes 3 → 5 (4 skipped) and trd_wait[4] = 1. refill_done with refill_trd = 4 two cycles later → thread 4 is selected on its next round-robin turn.
4. Thread 2 selected next and pc_wr[2] = 1 with nxt_pc_2 = 32'h0000_0100 in the same cycle → cur_pc = 32'h0000_0100 for cur_trd = 2, with no stale PC fetched.
5. stall = 1 for 3 cycles with cur_trd = 6 → cur_trd = 6 and cur_pc unchanged. A d_miss for thread 6 during the stall → i_rd = 0 the next cycle. After stall release, the search resumes from 7.
6. All threads waiting → i_rd = 0 (IDLE). Simultaneous refill_done for thread 1 and i_miss for thread 1 → thread 1 stays waiting. Assert rst_n low mid-run → all outputs return to reset values immediately.
